// File: rtl/hack_rom_loader.sv
// hack_rom_loader: fills the Hack instruction ROM from a big-endian byte
// stream (16-bit word count, then the words) and gates the CPU reset.
module hack_rom_loader #(
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    input  logic [7:0]            byte_in,
    input  logic                  byte_valid_in,
    output logic                  byte_ready_out,
    output logic                  rom_we_out,
    output logic [ADDR_WIDTH-1:0] rom_addr_out,
    output logic [15:0]           rom_data_out,
    output logic                  cpu_reset_out,
    output logic                  busy_out,
    output logic                  done_out,
    output logic                  error_out
);

    typedef enum logic [2:0] {
        IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE, ERROR
    } state_t;

    localparam logic [16:0] CAP = 17'(1) << ADDR_WIDTH;

    state_t                state_q, state_d;
    logic [15:0]           cnt_q, cnt_d;
    logic [7:0]            hi_q, hi_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [15:0]           wdata_q, wdata_d;
    logic                  xfer;
    logic                  last;

    assign xfer = byte_valid_in & byte_ready_out;
    assign last = (17'(addr_q) + 17'd1) == {1'b0, cnt_q};

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            addr_q  <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            addr_q  <= addr_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        addr_d  = addr_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        unique case (state_q)
            IDLE, DONE, ERROR: begin
                if (start_in) begin
                    state_d = LEN_HI;
                    addr_d  = '0;
                end
            end
            LEN_HI: begin
                if (xfer) begin
                    cnt_d[15:8] = byte_in;
                    state_d     = LEN_LO;
                end
            end
            LEN_LO: begin
                if (xfer) begin
                    cnt_d = {cnt_q[15:8], byte_in};
                    if (cnt_d == 16'd0 || {1'b0, cnt_d} > CAP)
                        state_d = ERROR;
                    else
                        state_d = DATA_HI;
                end
            end
            DATA_HI: begin
                if (xfer) begin
                    hi_d    = byte_in;
                    state_d = DATA_LO;
                end
            end
            DATA_LO: begin
                // ROM-facing address/data only change on entry to WRITE
                if (xfer) begin
                    wdata_d = {hi_q, byte_in};
                    waddr_d = addr_q;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (last) begin
                    state_d = DONE;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = DATA_HI;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign byte_ready_out = (state_q == LEN_HI) || (state_q == LEN_LO) ||
                            (state_q == DATA_HI) || (state_q == DATA_LO);
    assign busy_out       = byte_ready_out || (state_q == WRITE);
    assign rom_we_out     = (state_q == WRITE);
    assign rom_addr_out   = waddr_q;
    assign rom_data_out   = wdata_q;
    assign cpu_reset_out  = (state_q != DONE);
    assign done_out       = (state_q == DONE);
    assign error_out      = (state_q == ERROR);

endmodule

// File: tb/tb_hack_rom_loader.sv
// tb_hack_rom_loader: randomized loads on a 15-bit and a 4-bit ROM loader,
// checked against a byte-stream reference model.
module tb_hack_rom_loader;

    typedef logic [7:0] byte_t;

    logic        clk;
    logic        rst;
    logic [1:0]  start_v, valid_v;
    logic [7:0]  byte0, byte1;
    logic [1:0]  ready_v, we_v, cpur_v, busy_v, done_v, err_v;
    logic [14:0] addr0;
    logic [3:0]  addr1;
    logic [15:0] data0, data1;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_we_cyc = -1;
    int fall_cyc = -1;
    int got_q[$];
    logic [1:0] cpur_prev = 2'b11;

    hack_rom_loader #(.ADDR_WIDTH(15)) u_dut0 (
        .clk_in(clk), .rst_in(rst), .start_in(start_v[0]),
        .byte_in(byte0), .byte_valid_in(valid_v[0]),
        .byte_ready_out(ready_v[0]), .rom_we_out(we_v[0]),
        .rom_addr_out(addr0), .rom_data_out(data0),
        .cpu_reset_out(cpur_v[0]), .busy_out(busy_v[0]),
        .done_out(done_v[0]), .error_out(err_v[0])
    );

    hack_rom_loader #(.ADDR_WIDTH(4)) u_dut1 (
        .clk_in(clk), .rst_in(rst), .start_in(start_v[1]),
        .byte_in(byte1), .byte_valid_in(valid_v[1]),
        .byte_ready_out(ready_v[1]), .rom_we_out(we_v[1]),
        .rom_addr_out(addr1), .rom_data_out(data1),
        .cpu_reset_out(cpur_v[1]), .busy_out(busy_v[1]),
        .done_out(done_v[1]), .error_out(err_v[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (we_v[0]) begin
            got_q.push_back(int'({addr0, data0}));
            last_we_cyc = cyc;
        end
        if (we_v[1]) begin
            got_q.push_back(int'({addr1, data1}));
            last_we_cyc = cyc;
        end
        for (int d = 0; d < 2; d++)
            if (cpur_prev[d] && !cpur_v[d]) fall_cyc = cyc;
        cpur_prev = cpur_v;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int d, input byte_t b, input logic v);
        if (d == 0) begin
            byte0      = b;
            valid_v[0] = v;
        end else begin
            byte1      = b;
            valid_v[1] = v;
        end
    endtask

    task automatic pulse_start(input int d);
        start_v[d] = 1'b1;
        @(negedge clk);
        start_v[d] = 1'b0;
    endtask

    task automatic send_byte(input int d, input byte_t b, input int gap,
                             input int exp_nr, input bit st);
        int nr = 0;
        int w = 0;
        repeat (gap) begin
            drive(d, 8'h00, 1'b0);
            if (!ready_v[d]) nr++;
            @(negedge clk);
        end
        drive(d, b, 1'b1);
        while (!ready_v[d] && w < 8) begin
            nr++;
            w++;
            @(negedge clk);
        end
        if (st) start_v[d] = 1'b1;
        @(negedge clk);
        start_v[d] = 1'b0;
        drive(d, 8'h00, 1'b0);
        if (exp_nr >= 0) check("not_ready_cycles", nr, exp_nr);
    endtask

    task automatic check_reset(input int d);
        check("rst_ready", ready_v[d], 0);
        check("rst_we", we_v[d], 0);
        check("rst_addr", d == 0 ? 32'(addr0) : 32'(addr1), 0);
        check("rst_data", d == 0 ? 32'(data0) : 32'(data1), 0);
        check("rst_cpu_reset", cpur_v[d], 1);
        check("rst_busy", busy_v[d], 0);
        check("rst_done", done_v[d], 0);
        check("rst_error", err_v[d], 0);
    endtask

    // gap < 0 picks a random 0..3 idle cycles before every byte
    task automatic run_load(input int d, input byte_t bs[$], input int gap,
                            input int start_at);
        int aw = (d == 0) ? 15 : 4;
        int cnt = {bs[0], bs[1]};
        bit bad = (cnt == 0) || (cnt > (1 << aw));
        int nb = bad ? 2 : 2 + 2 * cnt;
        int exp_q[$];
        int k = 0;
        if (!bad)
            for (int i = 0; i < cnt; i++)
                exp_q.push_back((i << 16) | {bs[2 + 2 * i], bs[3 + 2 * i]});
        got_q.delete();
        last_we_cyc = -1;
        fall_cyc = -1;
        pulse_start(d);
        for (int i = 0; i < nb; i++) begin
            int g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            int enr = (i >= 4 && i % 2 == 0) ? 1 : 0;
            send_byte(d, bs[i], g, enr, i == start_at);
        end
        while (!(done_v[d] || err_v[d]) && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("finish_in_time", k < 10, 1);
        repeat (2) @(negedge clk);
        check("done", done_v[d], !bad);
        check("error", err_v[d], bad);
        check("cpu_reset", cpur_v[d], bad);
        check("busy", busy_v[d], 0);
        check("ready_idle", ready_v[d], 0);
        check("n_writes", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check("write_addr_data", got_q[i], exp_q[i]);
        if (!bad) check("cpu_reset_fall_cycle", fall_cyc, last_we_cyc + 1);
    endtask

    task automatic mk_load(input int cnt, input int nw, input bit seq,
                           output byte_t bs[$]);
        bs.delete();
        bs.push_back(byte_t'(cnt >> 8));
        bs.push_back(byte_t'(cnt));
        for (int i = 0; i < nw; i++) begin
            logic [15:0] w = seq ? 16'(i) : 16'($urandom);
            bs.push_back(w[15:8]);
            bs.push_back(w[7:0]);
        end
    endtask

    initial begin
        byte_t bs[$];
        int nr;
        rst = 1'b1;
        start_v = '0;
        valid_v = '0;
        byte0 = '0;
        byte1 = '0;
        repeat (3) @(negedge clk);
        check_reset(0);
        check_reset(1);
        rst = 1'b0;
        @(negedge clk);

        bs = '{8'h00, 8'h02, 8'hAB, 8'hCD, 8'h12, 8'h34};
        run_load(0, bs, 0, -1);

        bs = '{8'h00, 8'h00};
        run_load(0, bs, 0, -1);
        bs = '{8'h00, 8'h01, 8'h7F, 8'hFF};
        run_load(0, bs, 0, -1);

        mk_load(17, 0, 1'b1, bs);
        run_load(1, bs, 0, -1);
        mk_load(16, 16, 1'b1, bs);
        run_load(1, bs, 0, -1);

        mk_load(3, 3, 1'b0, bs);
        run_load(0, bs, 3, -1);
        for (int t = 0; t < 4; t++) begin
            mk_load(int'($urandom_range(1, 6)), 0, 1'b0, bs);
            mk_load({bs[0], bs[1]}, {bs[0], bs[1]}, 1'b0, bs);
            run_load(t % 2, bs, -1, -1);
        end

        mk_load(16'h8001, 0, 1'b1, bs);
        run_load(0, bs, 0, -1);
        mk_load(16'h8000, 0, 1'b1, bs);
        mk_load(16, 0, 1'b1, bs);
        bs[0] = 8'h00;
        bs[1] = 8'h00;
        run_load(1, bs, 0, -1);

        mk_load(2, 2, 1'b0, bs);
        run_load(0, bs, 0, 3);

        // reset (with a coincident start) right after the first of 4 writes
        got_q.delete();
        mk_load(4, 4, 1'b0, bs);
        pulse_start(1);
        for (int i = 0; i < 4; i++) send_byte(1, bs[i], 0, -1, 1'b0);
        check("we_before_reset", we_v[1], 1);
        rst = 1'b1;
        start_v[1] = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start_v[1] = 1'b0;
        check_reset(1);
        nr = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1, bs[4 + i], 1'b1);
            if (ready_v[1]) nr++;
            @(negedge clk);
        end
        drive(1, 8'h00, 1'b0);
        check("ready_after_reset", nr, 0);
        check("writes_after_reset", got_q.size(), 1);
        mk_load(3, 3, 1'b0, bs);
        run_load(1, bs, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hack_rom_loader.md
Name: hack_rom_loader

Overview:
- Writer side of the Hack instruction ROM. The CPU fetch path only reads the ROM; this block fills it.
- Accepts a byte stream over a valid/ready handshake: a 16-bit word count, then that many 16-bit instructions.
- Writes each instruction to consecutive ROM addresses starting at 0.
- Holds the Hack CPU in reset until a load completes successfully.

Parameters:
- ADDR_WIDTH, 15, ROM address width; capacity is 2^ADDR_WIDTH words (32K for the standard Hack ROM).

Ports:
- clk_in  input  1  system clock; all logic on rising edge.
- rst_in  input  1  synchronous, active-high reset.
- start_in  input  1  one-cycle pulse that begins a load.
- byte_in  input  8  stream byte.
- byte_valid_in  input  1  byte_in is valid.
- byte_ready_out  output  1  loader can accept a byte this cycle.
- rom_we_out  output  1  ROM write enable; one-cycle pulse per word.
- rom_addr_out  output  ADDR_WIDTH  ROM write address.
- rom_data_out  output  16  ROM write data (instruction).
- cpu_reset_out  output  1  holds the Hack CPU in reset.
- busy_out  output  1  a load is in progress.
- done_out  output  1  last load completed successfully.
- error_out  output  1  last load rejected because of a bad word count.

Behaviour:
- Interface decision: one clock, clk_in; reset rst_in is synchronous and active-high.
- Reset values (rst_in sampled high at a rising edge):
  - State IDLE.
  - byte_ready_out=0, rom_we_out=0, rom_addr_out=0, rom_data_out=0.
  - cpu_reset_out=1, busy_out=0, done_out=0, error_out=0.
  - Internal count and address registers cleared.
- Byte transfer occurs in a cycle where byte_valid_in=1 and byte_ready_out=1.
  - byte_ready_out is 1 only in states LEN_HI, LEN_LO, DATA_HI, DATA_LO.
  - byte_ready_out is a registered function of state; it does not depend on byte_valid_in.
  - Bytes presented while byte_ready_out=0 are not consumed.
- All multi-byte fields are big-endian: the high byte arrives first.
- States and transitions:
  - IDLE: start_in=1 -> LEN_HI; busy_out=1; done_out and error_out cleared; address cleared to 0.
  - LEN_HI: on transfer, latch count[15:8] -> LEN_LO.
  - LEN_LO: on transfer, latch count[7:0], then branch on the full 16-bit count:
    - count == 0 -> ERROR.
    - count > 2^ADDR_WIDTH -> ERROR.
    - otherwise -> DATA_HI.
  - DATA_HI: on transfer, latch word[15:8] -> DATA_LO.
  - DATA_LO: on transfer, latch word[7:0] -> WRITE.
  - WRITE (exactly one cycle):
    - rom_we_out=1, rom_addr_out=current address, rom_data_out=assembled word.
    - Next: if the number of words written equals count -> DONE; else increment address -> DATA_HI.
  - DONE: done_out=1, busy_out=0, cpu_reset_out=0; start_in=1 -> LEN_HI (same actions as from IDLE).
  - ERROR: error_out=1, busy_out=0, cpu_reset_out=1; start_in=1 -> LEN_HI (same actions as from IDLE).
- Latency: rom_we_out asserts in the cycle immediately after the low byte of a word is accepted.
- Throughput: best case is one word per 3 cycles.
- A word count of exactly 2^ADDR_WIDTH is legal.
  - The last write goes to address 2^ADDR_WIDTH-1.
  - The address does not wrap; the load ends in DONE.
- cpu_reset_out is 1 in every state except DONE, so the CPU runs only from a completely loaded ROM. It drops the cycle DONE is entered.
- rom_addr_out and rom_data_out hold their last values outside WRITE. They are valid only when rom_we_out=1.
- start_in during LEN_HI..WRITE is ignored; it does not restart the load.
- Stalls: byte_valid_in may deassert between any bytes for any number of cycles; state holds.
- rst_in mid-load returns to IDLE with reset values.
  - No further ROM writes occur.
  - Already-written ROM words are not cleared.
- start_in and rst_in high in the same cycle: reset wins.

Test Plan:
- Reset, pulse start_in, stream 00 02 / AB CD / 12 34, byte_valid_in held high -> rom_we_out pulses twice: (addr 0, 0xABCD) then (addr 1, 0x1234). done_out=1, cpu_reset_out falls to 0 the cycle DONE is entered, busy_out=0.
- Stream count 00 00 -> ERROR: error_out=1, cpu_reset_out=1, no rom_we_out pulses. A following start_in plus valid count-1 load (00 01 / 7F FF) writes 0x7FFF at addr 0 and ends with done_out=1.
- ADDR_WIDTH=4, count 00 11 (17 > 16) -> error_out=1. Count 00 10 with words 0x0000..0x000F -> 16 writes at addr 0..15, last at addr 15, done_out=1, no wrap.
- Random byte_valid_in gaps (e.g. 3 idle cycles between every byte) for count 3 -> identical ROM writes and order; byte_ready_out never drops while waiting in a byte state.
- Assert rst_in after the first of 4 words is written -> next cycle all outputs at reset values, no further rom_we_out, cpu_reset_out=1; extra bytes offered are not accepted until a new start_in.
- start_in pulsed during DATA_LO of a 2-word load -> ignored; load completes normally with 2 writes and done_out=1.
